// File: rtl/controller_pkg.sv
// controller_pkg: shared state encoding, opcodes, ALU codes and instruction field positions.
package controller_pkg;
    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_LOAD_A = 4'd3,
        S_LOAD_B = 4'd4,
        S_STORE  = 4'd5,
        S_ADD    = 4'd6,
        S_SUB    = 4'd7,
        S_NOOP   = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    localparam logic [3:0] OP_NOOP  = 4'b0000;
    localparam logic [3:0] OP_STORE = 4'b0001;
    localparam logic [3:0] OP_LOAD  = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0100;
    localparam logic [3:0] OP_HALT  = 4'b0101;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;

    localparam int OP_LSB = 12;
    localparam int HI_LSB = 8;
    localparam int MID_LSB = 4;
    localparam int LO_LSB = 0;
endpackage

// File: rtl/program_counter.sv
// program_counter: PC_W-bit wrapping instruction address with async clear and increment enable.
module program_counter #(
    parameter int PC_W = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    output logic [PC_W-1:0] pc
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc <= '0;
        else if (en) pc <= pc + 1'b1;
    end
endmodule

// File: rtl/controller_unit.sv
// controller_unit: Moore FSM sequencing fetch/decode/execute of a 16-bit instruction set.
module controller_unit
    import controller_pkg::*;
#(
    parameter int PC_W = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            Start,
    input  logic [15:0]     IR_Data,
    output logic [PC_W-1:0] PC_Addr,
    output logic [3:0]      D_Addr,
    output logic            D_WriteEn,
    output logic            MuxS,
    output logic [3:0]      RegF_W_addr,
    output logic [3:0]      RegF_Ra_addr,
    output logic [3:0]      RegF_Rb_addr,
    output logic            RegF_W_en,
    output logic [2:0]      ALU_S,
    output logic            Halted,
    output logic [3:0]      State_Out
);
    state_t state, next;
    logic [15:0] ir;
    logic [3:0] f_hi, f_mid, f_lo;

    program_counter #(.PC_W(PC_W)) u_pc (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state == S_FETCH),
        .pc    (PC_Addr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_INIT;
            ir <= '0;
        end else begin
            state <= next;
            if (state == S_FETCH) ir <= IR_Data;
        end
    end

    always_comb begin
        next = state;
        case (state)
            S_INIT:   next = Start ? S_FETCH : S_INIT;
            S_FETCH:  next = S_DECODE;
            S_DECODE:
                case (ir[OP_LSB +: 4])
                    OP_STORE: next = S_STORE;
                    OP_LOAD:  next = S_LOAD_A;
                    OP_ADD:   next = S_ADD;
                    OP_SUB:   next = S_SUB;
                    OP_HALT:  next = S_HALT;
                    default:  next = S_NOOP;
                endcase
            S_LOAD_A: next = S_LOAD_B;
            S_HALT:   next = S_HALT;
            default:  next = S_FETCH;
        endcase
    end

    assign f_hi = ir[HI_LSB +: 4];
    assign f_mid = ir[MID_LSB +: 4];
    assign f_lo = ir[LO_LSB +: 4];

    // Everything below depends only on registered state and IR, so reset clears it at once.
    always_comb begin
        D_Addr = '0;
        D_WriteEn = 1'b0;
        MuxS = 1'b0;
        RegF_W_addr = '0;
        RegF_Ra_addr = '0;
        RegF_Rb_addr = '0;
        RegF_W_en = 1'b0;
        ALU_S = ALU_PASS;
        case (state)
            S_LOAD_A, S_LOAD_B: begin
                D_Addr = f_hi;
                RegF_W_addr = f_lo;
                MuxS = 1'b1;
                RegF_W_en = state == S_LOAD_B;
            end
            S_STORE: begin
                RegF_Ra_addr = f_hi;
                D_Addr = f_mid;
                D_WriteEn = 1'b1;
            end
            S_ADD, S_SUB: begin
                RegF_Ra_addr = f_hi;
                RegF_Rb_addr = f_mid;
                RegF_W_addr = f_lo;
                RegF_W_en = 1'b1;
                ALU_S = state == S_ADD ? ALU_ADD : ALU_SUB;
            end
            default: ;
        endcase
    end

    assign Halted = state == S_HALT;
    assign State_Out = state;
endmodule

// File: tb/tb_controller_unit.sv
// tb_controller_unit: directed checks of controller_unit against a synchronous ROM model.
module tb_controller_unit;
    logic        clk, rst_n, start;
    logic [15:0] ir_data;
    logic [6:0]  pc_addr;
    logic [3:0]  d_addr, w_addr, ra_addr, rb_addr, state_out;
    logic        d_we, mux_s, w_en, halted;
    logic [2:0]  alu_s;
    logic [15:0] rom [128];
    logic [21:0] outs;
    int n_chk = 0;
    int n_pass = 0;

    controller_unit #(.PC_W(7)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .Start        (start),
        .IR_Data      (ir_data),
        .PC_Addr      (pc_addr),
        .D_Addr       (d_addr),
        .D_WriteEn    (d_we),
        .MuxS         (mux_s),
        .RegF_W_addr  (w_addr),
        .RegF_Ra_addr (ra_addr),
        .RegF_Rb_addr (rb_addr),
        .RegF_W_en    (w_en),
        .ALU_S        (alu_s),
        .Halted       (halted),
        .State_Out    (state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) ir_data <= rom[pc_addr];

    assign outs = {d_addr, d_we, mux_s, w_addr, ra_addr, rb_addr, w_en, alu_s};

    function automatic logic [21:0] pack(input logic [3:0] da, input logic we, input logic ms,
                                         input logic [3:0] wa, input logic [3:0] ra,
                                         input logic [3:0] rb, input logic wen, input logic [2:0] alu);
        return {da, we, ms, wa, ra, rb, wen, alu};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic clear_rom(input logic [15:0] w);
        for (int i = 0; i < 128; i++) rom[i] = w;
    endtask

    // Reset, check the reset state, idle in INIT, then start and land in FETCH.
    task automatic reset_and_start();
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        check("rst_state", 32'(state_out), 32'd0);
        check("rst_pc", 32'(pc_addr), 32'd0);
        check("rst_outs", 32'(outs), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("idle_init", 32'(state_out), 32'd0);
        check("idle_outs", 32'(outs), 32'd0);
        start = 1'b1;
        @(negedge clk);
        check("start_fetch", 32'(state_out), 32'd1);
        check("fetch_pc", 32'(pc_addr), 32'd0);
        check("fetch_outs", 32'(outs), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        clear_rom(16'h0000);
        rom[0] = 16'h2A05;
        reset_and_start();
        @(negedge clk);
        check("ld_decode", 32'(state_out), 32'd2);
        check("ld_pc1", 32'(pc_addr), 32'd1);
        check("ld_dec_outs", 32'(outs), 32'd0);
        @(negedge clk);
        check("ld_a_state", 32'(state_out), 32'd3);
        check("ld_a_outs", 32'(outs), 32'(pack(4'd10, 0, 1, 4'd5, 0, 0, 0, 3'd0)));
        @(negedge clk);
        check("ld_b_state", 32'(state_out), 32'd4);
        check("ld_b_outs", 32'(outs), 32'(pack(4'd10, 0, 1, 4'd5, 0, 0, 1, 3'd0)));
        @(negedge clk);
        check("ld_next_fetch", 32'(state_out), 32'd1);

        clear_rom(16'h0000);
        rom[0] = 16'h3123;
        rom[1] = 16'h4567;
        reset_and_start();
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("add_state", 32'(state_out), 32'd6);
        check("add_outs", 32'(outs), 32'(pack(0, 0, 0, 4'd3, 4'd1, 4'd2, 1, 3'b001)));
        @(negedge clk);
        check("add_next_fetch", 32'(state_out), 32'd1);
        check("add_pc", 32'(pc_addr), 32'd1);
        @(negedge clk);
        @(negedge clk);
        check("sub_state", 32'(state_out), 32'd7);
        check("sub_outs", 32'(outs), 32'(pack(0, 0, 0, 4'd7, 4'd5, 4'd6, 1, 3'b010)));
        @(negedge clk);
        check("sub_next_fetch", 32'(state_out), 32'd1);

        clear_rom(16'h0000);
        rom[0] = 16'h1370;
        rom[1] = 16'h5000;
        reset_and_start();
        @(negedge clk);
        @(negedge clk);
        check("st_state", 32'(state_out), 32'd5);
        check("st_outs", 32'(outs), 32'(pack(4'd7, 1, 0, 0, 4'd3, 0, 0, 3'd0)));
        @(negedge clk);
        check("st_next_fetch", 32'(state_out), 32'd1);
        check("st_next_outs", 32'(outs), 32'd0);
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 24; i++) begin
            check("halt_state", 32'(state_out), 32'd9);
            check("halt_flag", 32'(halted), 32'd1);
            check("halt_outs", 32'(outs), 32'd0);
            start = ~start;
            @(negedge clk);
        end
        check("halt_pc", 32'(pc_addr), 32'd2);
        rst_n = 1'b0;
        #1;
        check("halt_rst_flag", 32'(halted), 32'd0);
        check("halt_rst_state", 32'(state_out), 32'd0);

        for (int i = 0; i < 128; i++) rom[i] = (i % 3 == 0) ? 16'hF123 : 16'h0ABC;
        reset_and_start();
        start = 1'b0;
        for (int i = 0; i < 130; i++) begin
            check("nop_fetch", 32'(state_out), 32'd1);
            check("nop_pc", 32'(pc_addr), 32'(i % 128));
            @(negedge clk);
            check("nop_decode", 32'(state_out), 32'd2);
            check("nop_dec_outs", 32'(outs), 32'd0);
            @(negedge clk);
            check("nop_exec", 32'(state_out), 32'd8);
            check("nop_exec_outs", 32'(outs), 32'd0);
            @(negedge clk);
        end

        clear_rom(16'h0000);
        rom[0] = 16'h2A05;
        reset_and_start();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("mid_ld_b_wen", 32'(w_en), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_wen", 32'(w_en), 32'd0);
        check("mid_rst_state", 32'(state_out), 32'd0);
        check("mid_rst_pc", 32'(pc_addr), 32'd0);
        check("mid_rst_halted", 32'(halted), 32'd0);
        check("mid_rst_outs", 32'(outs), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_post_init", 32'(state_out), 32'd0);
        check("mid_post_outs", 32'(outs), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
